// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode defaults, CPU opcode encodings and a width helper.
// Latency: n/a (package). Backpressure: n/a.
// Imported by the elastic pipeline, its stages and the hazard/forwarding logic.
package pipe_pkg;

   localparam int OPCODE_W_DEF = 4;
   localparam logic [OPCODE_W_DEF-1:0] NOP_OPCODE_DEF = '0;

   // CPU opcode encodings inspected by hazard logic through stage_opcode.
   localparam logic [OPCODE_W_DEF-1:0] OPCODE_ADD = 4'h1;
   localparam logic [OPCODE_W_DEF-1:0] OPCODE_SUB = 4'h2;
   localparam logic [OPCODE_W_DEF-1:0] OPCODE_AND = 4'h3;
   localparam logic [OPCODE_W_DEF-1:0] OPCODE_OR  = 4'h4;
   localparam logic [OPCODE_W_DEF-1:0] OPCODE_XOR = 4'h5;
   localparam logic [OPCODE_W_DEF-1:0] OPCODE_SHL = 4'h6;
   localparam logic [OPCODE_W_DEF-1:0] OPCODE_SHR = 4'h7;
   localparam logic [OPCODE_W_DEF-1:0] OPCODE_LD  = 4'h8;
   localparam logic [OPCODE_W_DEF-1:0] OPCODE_ST  = 4'h9;
   localparam logic [OPCODE_W_DEF-1:0] OPCODE_BEQ = 4'hA;
   localparam logic [OPCODE_W_DEF-1:0] OPCODE_JMP = 4'hB;
   localparam logic [OPCODE_W_DEF-1:0] OPCODE_HLT = 4'hF;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic stage register holding valid, opcode and payload.
// Latency: 1 cycle. Backpressure: hold freezes the stage; flush overrides hold and load.
// Invalidated stages carry NOP_OPCODE; the payload is left untouched when bubbling.
module pipe_stage import pipe_pkg::*; #(
   parameter int WIDTH = 64,
   parameter int OPCODE_W = OPCODE_W_DEF,
   parameter logic [OPCODE_W-1:0] NOP_OPCODE = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                hold,
   input  logic                load,
   input  logic                bubble,
   input  logic [OPCODE_W-1:0] load_opcode,
   input  logic [WIDTH-1:0]    load_data,
   output logic                valid_nxt,
   output logic                valid,
   output logic [OPCODE_W-1:0] opcode,
   output logic [WIDTH-1:0]    data
);

   logic [OPCODE_W-1:0] opcode_nxt;
   logic [WIDTH-1:0]    data_nxt;

   always_comb begin
      valid_nxt  = valid;
      opcode_nxt = opcode;
      data_nxt   = data;
      if (flush) begin
         valid_nxt  = 1'b0;
         opcode_nxt = NOP_OPCODE;
      end else if (!hold) begin
         if (load) begin
            valid_nxt  = 1'b1;
            opcode_nxt = load_opcode;
            data_nxt   = load_data;
         end else if (bubble) begin
            valid_nxt  = 1'b0;
            opcode_nxt = NOP_OPCODE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid  <= 1'b0;
         opcode <= NOP_OPCODE;
         data   <= '0;
      end else begin
         valid  <= valid_nxt;
         opcode <= opcode_nxt;
         data   <= data_nxt;
      end
   end

endmodule

// File: rtl/elastic_pipeline.sv
// DEPTH-stage elastic pipeline with per-stage hold, indexed flush and stage visibility.
// Latency: DEPTH cycles from accept to out_valid, 1 beat/cycle throughput.
// Backpressure: combinational ready chain from out_ready back to in_ready.
module elastic_pipeline import pipe_pkg::*; #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   parameter int OPCODE_W = OPCODE_W_DEF,
   parameter logic [OPCODE_W-1:0] NOP_OPCODE = OPCODE_W'(NOP_OPCODE_DEF)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [OPCODE_W-1:0]          in_opcode,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OPCODE_W-1:0]          out_opcode,
   output logic [WIDTH-1:0]             out_data,
   input  logic [DEPTH-1:0]             hold,
   input  logic                         flush_valid,
   input  logic [clog2(DEPTH)-1:0]      flush_stage,
   output logic [DEPTH-1:0]             stage_valid,
   output logic [DEPTH*OPCODE_W-1:0]    stage_opcode,
   output logic [clog2(DEPTH+1)-1:0]    occupancy
);

   localparam int OCC_W = clog2(DEPTH + 1);

   logic [DEPTH:0]      ready;
   logic [DEPTH-1:0]    pass;
   logic [DEPTH-1:0]    flushed;
   logic [DEPTH-1:0]    load;
   logic [DEPTH-1:0]    valid_nxt;
   logic [OPCODE_W-1:0] op_q     [DEPTH];
   logic [WIDTH-1:0]    data_q   [DEPTH];
   logic [OPCODE_W-1:0] src_op   [DEPTH];
   logic [WIDTH-1:0]    src_data [DEPTH];
   logic [OCC_W-1:0]    occ_nxt;

   // Ready ripples from the oldest stage towards the input.
   always_comb begin
      ready        = '0;
      pass         = '0;
      ready[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         pass[i]  = stage_valid[i] & ~hold[i] & ready[i+1];
         ready[i] = ~hold[i] & (~stage_valid[i] | ready[i+1]);
      end
   end

   assign in_ready = ready[0] & ~flush_valid;

   // A flushed stage never hands its beat forward, so its successor bubbles.
   always_comb begin
      flushed     = '0;
      load        = '0;
      src_op[0]   = in_opcode;
      src_data[0] = in_data;
      for (int i = 0; i < DEPTH; i++) begin
         flushed[i] = flush_valid & (i <= int'(flush_stage));
      end
      load[0] = in_valid & in_ready;
      for (int i = 1; i < DEPTH; i++) begin
         load[i]     = pass[i-1] & ~flushed[i-1];
         src_op[i]   = op_q[i-1];
         src_data[i] = data_q[i-1];
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      pipe_stage #(
         .WIDTH      (WIDTH),
         .OPCODE_W   (OPCODE_W),
         .NOP_OPCODE (NOP_OPCODE)
      ) u_stage (
         .clk         (clk),
         .rst_n       (rst_n),
         .flush       (flushed[g]),
         .hold        (hold[g]),
         .load        (load[g]),
         .bubble      (pass[g]),
         .load_opcode (src_op[g]),
         .load_data   (src_data[g]),
         .valid_nxt   (valid_nxt[g]),
         .valid       (stage_valid[g]),
         .opcode      (op_q[g]),
         .data        (data_q[g])
      );
      assign stage_opcode[g*OPCODE_W +: OPCODE_W] = op_q[g];
   end

   assign out_valid  = stage_valid[DEPTH-1];
   assign out_opcode = op_q[DEPTH-1];
   assign out_data   = data_q[DEPTH-1];

   always_comb begin
      occ_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ_nxt = occ_nxt + OCC_W'(valid_nxt[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) occupancy <= '0;
      else        occupancy <= occ_nxt;
   end

endmodule
